// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Contents:
//   IMEM_ADDR_W  - instruction-memory word-address width (depth = 2**IMEM_ADDR_W)
//   BOOT_LEN_W   - width of the image word-count header
//   boot_state_e - loader FSM states
//   accepts_byte - true for the states that take a stream byte
package mips_pkg;

  localparam int IMEM_ADDR_W = 10;
  localparam int BOOT_LEN_W  = 16;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    FINISH,
    DONE,
    ERR
  } boot_state_e;

  function automatic logic accepts_byte(input boot_state_e s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/boot_word_asm.sv
// Assembles big-endian stream bytes into 32-bit instruction words.
// Optional feature macro: IMEM_BOOT_CHECKSUM_EN (adds the running XOR of body bytes).
// Ports:
//   clk, rst   - clock and asynchronous active-high reset
//   clear      - drop any partial word and restart the byte count / XOR
//   take       - a body byte is transferred this cycle
//   byte_in    - the body byte
//   last_byte  - the byte being taken completes a word
//   word_valid - one-cycle pulse, word holds a complete word
//   word       - last completed word (MSB first)
//   xor_acc    - running XOR of all body bytes (checksum build only)
module boot_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  byte_in,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
`ifdef IMEM_BOOT_CHECKSUM_EN
  ,
  output logic [7:0]  xor_acc
`endif
);

  // Only the first three bytes of a word need holding; the fourth comes
  // straight from byte_in when the word is completed.
  logic [23:0] shift;
  logic [1:0]  byte_cnt;

  assign last_byte = (byte_cnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift      <= '0;
      byte_cnt   <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        shift    <= '0;
        byte_cnt <= '0;
      end else if (take) begin
        shift    <= {shift[15:0], byte_in};
        byte_cnt <= byte_cnt + 2'd1;
        if (last_byte) begin
          word_valid <= 1'b1;
          word       <= {shift, byte_in};
        end
      end
    end
  end

`ifdef IMEM_BOOT_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xor_acc <= '0;
    end else if (clear) begin
      xor_acc <= '0;
    end else if (take) begin
      xor_acc <= xor_acc ^ byte_in;
    end
  end
`endif

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a program image as a byte stream, writes it into
// instruction memory word by word, and holds the mips core in reset until
// the image is loaded.
// Image: 2-byte big-endian word count N, then 4*N body bytes (big-endian words),
// then one XOR checksum byte when IMEM_BOOT_CHECKSUM_EN is defined.
// Ports:
//   clk, rst            - clock and asynchronous active-high reset
//   rx_valid/rx_data    - incoming stream byte; rx_ready - byte accepted
//   reload              - pulse; restarts loading from DONE or ERR
//   im_we/im_addr/im_wdata - instruction-memory write port
//   cpu_rst_n           - active-low core reset
//   done / err          - image loaded and core running / load failed
module imem_boot_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int LEN_W  = BOOT_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err
);

  localparam logic [LEN_W:0] DEPTH = (LEN_W + 1)'(1) << ADDR_W;

`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam boot_state_e BODY_END = CSUM;
  logic [7:0] xor_acc;
`else
  localparam boot_state_e BODY_END = FINISH;
`endif

  boot_state_e      state, next_state;
  logic [7:0]       len_hi;
  logic [LEN_W-1:0] len, word_idx, hdr_len;
  logic             fire, take, last_byte, core_run;

  assign fire      = rx_valid && rx_ready;
  assign take      = fire && (state == DATA);
  assign hdr_len   = LEN_W'({len_hi, rx_data});
  assign cpu_rst_n = core_run;
  assign done      = core_run;

  boot_word_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == LEN_HI),
    .take       (take),
    .byte_in    (rx_data),
    .last_byte  (last_byte),
    .word_valid (im_we),
    .word       (im_wdata)
`ifdef IMEM_BOOT_CHECKSUM_EN
    ,
    .xor_acc    (xor_acc)
`endif
  );

  // Next-state logic. The length check happens as the low header byte arrives,
  // so an oversized image never writes anything.
  always_comb begin
    next_state = state;
    case (state)
      LEN_HI: if (fire) next_state = LEN_LO;
      LEN_LO: begin
        if (fire) begin
          if (hdr_len == '0)                    next_state = BODY_END;
          else if ({1'b0, hdr_len} > DEPTH)     next_state = ERR;
          else                                  next_state = DATA;
        end
      end
      DATA: begin
        if (take && last_byte && (word_idx + LEN_W'(1) == len)) next_state = BODY_END;
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      CSUM: begin
        if (fire) next_state = (rx_data == xor_acc) ? FINISH : ERR;
      end
`endif
      FINISH: next_state = DONE;
      DONE:   if (reload) next_state = LEN_HI;
      ERR:    if (reload) next_state = LEN_HI;
      default: next_state = LEN_HI;
    endcase
  end

  // State register and registered outputs. The core is released one cycle
  // after entering DONE so the last write has fully retired, and drops back
  // into reset on the same edge that a reload takes effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LEN_HI;
      rx_ready <= 1'b0;
      err      <= 1'b0;
      core_run <= 1'b0;
      im_addr  <= '0;
      len_hi   <= '0;
      len      <= '0;
      word_idx <= '0;
    end else begin
      state    <= next_state;
      rx_ready <= accepts_byte(next_state);
      err      <= (next_state == ERR);
      core_run <= (state == DONE) && !reload;
      if (state == LEN_HI) word_idx <= '0;
      if (fire && (state == LEN_HI)) len_hi <= rx_data;
      if (fire && (state == LEN_LO)) len <= hdr_len;
      if (take && last_byte) begin
        im_addr  <= word_idx[ADDR_W-1:0];
        word_idx <= word_idx + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: table-driven cycle vectors plus hand-written
// sequences for asynchronous reset mid-image and a full-depth image.
// Honours IMEM_BOOT_CHECKSUM_EN when the design is built with it.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        reload = 1'b0;
  logic        rx_ready, im_we, cpu_rst_n, done, err;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;

  int checks = 0;
  int errors = 0;

`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  imem_boot_loader dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .reload    (reload),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .cpu_rst_n (cpu_rst_n),
    .done      (done),
    .err       (err)
  );

  // One row = inputs for one clock, then the outputs expected just after that edge.
  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rl;
    logic        rdy;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic        run;
    logic        er;
  } vec_t;

  vec_t tbl[$];

  logic [9:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  // Every memory write is captured mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (!rst && im_we === 1'b1) begin
      wr_addr_q.push_back(im_addr);
      wr_data_q.push_back(im_wdata);
    end
  end

  function automatic void row(input logic v, input logic [7:0] d, input logic rl,
                              input logic rdy, input logic we, input logic [9:0] addr,
                              input logic [31:0] wd, input logic run, input logic er);
    vec_t t;
    t.v = v; t.d = d; t.rl = rl; t.rdy = rdy; t.we = we;
    t.addr = addr; t.wd = wd; t.run = run; t.er = er;
    tbl.push_back(t);
  endfunction

  function automatic void byteRow(input logic [7:0] d);
    row(1'b1, d, 1'b0, 1'b1, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0);
  endfunction

  function automatic void idleRow();
    row(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0);
  endfunction

  function automatic void wordRow(input logic [7:0] d, input logic [9:0] addr, input logic [31:0] wd);
    row(1'b1, d, 1'b0, 1'b1, 1'b1, addr, wd, 1'b0, 1'b0);
  endfunction

  // Last body byte: with a checksum the loader still wants one more byte.
  function automatic void lastRow(input logic [7:0] d, input logic [9:0] addr, input logic [31:0] wd);
    row(1'b1, d, 1'b0, CSUM_ON, 1'b1, addr, wd, 1'b0, 1'b0);
  endfunction

  // FINISH -> DONE, then the core is released.
  function automatic void tailRows();
    row(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0);
    row(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0);
  endfunction

  function automatic void reloadRow();
    row(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic rl);
    rx_valid = v;
    rx_data  = d;
    reload   = rl;
    @(posedge clk);
    #1;
    reload   = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic waitDone(input int budget, input string name);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      n++;
    end
    checkOutput(name, {31'd0, done}, 32'd1);
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) applyStimulus(1'b1, w[8*b +: 8], 1'b0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;
    logic [7:0]  csum;
    logic [31:0] w;

    // A: two-word image, rx_valid held high
    idleRow();
    byteRow(8'h00); byteRow(8'h02);
    byteRow(8'h3C); byteRow(8'h08); byteRow(8'h00); wordRow(8'h01, 10'd0, 32'h3C080001);
    byteRow(8'h21); byteRow(8'h08); byteRow(8'h00); lastRow(8'h05, 10'd1, 32'h21080005);
`ifdef IMEM_BOOT_CHECKSUM_EN
    row(1'b1, 8'h19, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0);
`endif
    tailRows();
    row(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0);
    // B: same image, rx_valid toggling
    reloadRow();
    byteRow(8'h00); idleRow(); byteRow(8'h02); idleRow();
    byteRow(8'h3C); idleRow(); byteRow(8'h08); idleRow(); byteRow(8'h00); idleRow();
    wordRow(8'h01, 10'd0, 32'h3C080001); idleRow();
    byteRow(8'h21); idleRow(); byteRow(8'h08); idleRow(); byteRow(8'h00); idleRow();
    lastRow(8'h05, 10'd1, 32'h21080005);
`ifdef IMEM_BOOT_CHECKSUM_EN
    row(1'b1, 8'h19, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0);
`endif
    tailRows();
    // C: N=1025 is too large; reload outside DONE/ERR is ignored
    reloadRow();
    row(1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0);
    row(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b1);
    row(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b1);
    row(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b1);
    reloadRow();
    // D: empty image
    byteRow(8'h00);
`ifdef IMEM_BOOT_CHECKSUM_EN
    byteRow(8'h00);
`endif
    row(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0);
    tailRows();
`ifdef IMEM_BOOT_CHECKSUM_EN
    // E: wrong checksum byte
    reloadRow();
    byteRow(8'h00); byteRow(8'h02);
    byteRow(8'h3C); byteRow(8'h08); byteRow(8'h00); wordRow(8'h01, 10'd0, 32'h3C080001);
    byteRow(8'h21); byteRow(8'h08); byteRow(8'h00); lastRow(8'h05, 10'd1, 32'h21080005);
    row(1'b1, 8'h1A, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b1);
    row(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b1);
    reloadRow();
`endif

    // Reset state
    #12;
    checkOutput("reset_rx_ready", {31'd0, rx_ready}, 32'd0);
    checkOutput("reset_im_we", {31'd0, im_we}, 32'd0);
    checkOutput("reset_im_addr", {22'd0, im_addr}, 32'd0);
    checkOutput("reset_im_wdata", im_wdata, 32'd0);
    checkOutput("reset_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].v, tbl[i].d, tbl[i].rl);
      checkOutput($sformatf("row%0d_rx_ready", i), {31'd0, rx_ready}, {31'd0, tbl[i].rdy});
      checkOutput($sformatf("row%0d_im_we", i), {31'd0, im_we}, {31'd0, tbl[i].we});
      checkOutput($sformatf("row%0d_cpu_rst_n", i), {31'd0, cpu_rst_n}, {31'd0, tbl[i].run});
      checkOutput($sformatf("row%0d_done", i), {31'd0, done}, {31'd0, tbl[i].run});
      checkOutput($sformatf("row%0d_err", i), {31'd0, err}, {31'd0, tbl[i].er});
      if (tbl[i].we) begin
        checkOutput($sformatf("row%0d_im_addr", i), {22'd0, im_addr}, {22'd0, tbl[i].addr});
        checkOutput($sformatf("row%0d_im_wdata", i), im_wdata, tbl[i].wd);
      end
    end

    // Asynchronous reset after six body bytes, then a clean reload
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0);
    sendWord(32'h3C080001);
    applyStimulus(1'b1, 8'h21, 1'b0);
    applyStimulus(1'b1, 8'h08, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_rx_ready", {31'd0, rx_ready}, 32'd0);
    checkOutput("arst_im_we", {31'd0, im_we}, 32'd0);
    checkOutput("arst_im_addr", {22'd0, im_addr}, 32'd0);
    checkOutput("arst_im_wdata", im_wdata, 32'd0);
    checkOutput("arst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    checkOutput("arst_done", {31'd0, done}, 32'd0);
    checkOutput("arst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    wr_addr_q.delete();
    wr_data_q.delete();
    applyStimulus(1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0);
    sendWord(32'h3C080001);
    sendWord(32'h21080005);
`ifdef IMEM_BOOT_CHECKSUM_EN
    applyStimulus(1'b1, 8'h19, 1'b0);
`endif
    waitDone(10, "after_rst_done");
    checkOutput("after_rst_writes", wr_addr_q.size(), 32'd2);
    if (wr_addr_q.size() >= 2) begin
      checkOutput("after_rst_addr0", {22'd0, wr_addr_q[0]}, 32'd0);
      checkOutput("after_rst_data0", wr_data_q[0], 32'h3C080001);
      checkOutput("after_rst_addr1", {22'd0, wr_addr_q[1]}, 32'd1);
      checkOutput("after_rst_data1", wr_data_q[1], 32'h21080005);
    end

    // Full-depth image: N == 1024, last address all-ones
    applyStimulus(1'b0, 8'h00, 1'b1);
    wr_addr_q.delete();
    wr_data_q.delete();
    csum = 8'h00;
    applyStimulus(1'b1, 8'h04, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 1024; k++) begin
      w = 32'hC000_0000 | 32'(k);
      csum = csum ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      sendWord(w);
    end
`ifdef IMEM_BOOT_CHECKSUM_EN
    applyStimulus(1'b1, csum, 1'b0);
`endif
    waitDone(10, "full_done");
    checkOutput("full_writes", wr_addr_q.size(), 32'd1024);
    bad = 0;
    foreach (wr_addr_q[k]) begin
      if (wr_addr_q[k] !== 10'(k) || wr_data_q[k] !== (32'hC000_0000 | 32'(k))) bad++;
    end
    checkOutput("full_seq_bad", bad, 32'd0);
    if (wr_addr_q.size() > 0) checkOutput("full_last_addr", {22'd0, wr_addr_q[$]}, 32'h3FF);
    checkOutput("full_err", {31'd0, err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
